dmem_lsu: RTL and testbench

- Load/store initiator for the 32-bit data memory. It sits between the pipeline MEM stage and the single-port word RAM, which has a registered address/data/wren, an unregistered q, and no byte enables.
- Sequences word reads, word writes, and read-modify-write (RMW) for byte and halfword stores.
- Extracts and sign- or zero-extends load data.
- Returns one response per accepted request, with an error flag for misaligned or illegal requests.

---
 rtl/dmem_lsu.sv | 250 +++++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the MEM stage and a single-port
// 32-bit word RAM without byte enables. Sub-word stores are performed as
// read-modify-write. Load data is extracted and sign/zero extended here.
// Exactly one response pulse is returned per accepted request.

`ifndef DATA_W
`define DATA_W 32
`endif

module dmem_lsu #(
  parameter int D_WIDTH = `DATA_W,
  parameter int A_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [D_WIDTH-1:0] ram_address,
  output logic [D_WIDTH-1:0] ram_data,
  output logic               ram_wren,
  input  logic [D_WIDTH-1:0] ram_q
);

  // Sequencer states
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] RD_ISSUE = 2'b01;
  localparam logic [1:0] RD_WAIT  = 2'b10;
  localparam logic [1:0] WR       = 2'b11;

  // RV32I funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Extract the addressed lane from a RAM word and extend it for the load type.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [2:0]  funct3,
    input logic [1:0]  lane
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result;
    case (lane)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    if (lane[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_W:    result = word;
      F3_BU:   result = {24'h000000, byte_v};
      F3_HU:   result = {16'h0000, half_v};
      default: result = 32'h00000000;
    endcase
    return result;
  endfunction

  // Replace the target lane of the old RAM word with the store data.
  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [2:0]  funct3,
    input logic [1:0]  lane
  );
    logic [31:0] result;
    result = word;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'b00:   result[7:0]   = wdata[7:0];
          2'b01:   result[15:8]  = wdata[7:0];
          2'b10:   result[23:16] = wdata[7:0];
          2'b11:   result[31:24] = wdata[7:0];
          default: result        = word;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          result[31:16] = wdata[15:0];
        end else begin
          result[15:0] = wdata[15:0];
        end
      end
      default: result = wdata;
    endcase
    return result;
  endfunction

  logic [1:0]         state_r;
  logic               we_r;
  logic [2:0]         funct3_r;
  logic [1:0]         lane_r;
  logic [31:0]        wdata_r;

  logic               accept_s;
  logic               illegal_s;
  logic               misaligned_s;
  logic [D_WIDTH-1:0] word_addr_s;

  logic [1:0]         state_nxt_s;
  logic               latch_en_s;
  logic               rsp_valid_nxt_s;
  logic [31:0]        rsp_rdata_nxt_s;
  logic               rsp_err_nxt_s;
  logic [D_WIDTH-1:0] ram_address_nxt_s;
  logic [D_WIDTH-1:0] ram_data_nxt_s;
  logic               ram_wren_nxt_s;

  // Address bits above the memory size are deliberately ignored (wrap).
  logic               unused_addr_hi;
  assign unused_addr_hi = &{1'b0, req_addr[31:A_WIDTH+2]};

  assign req_ready   = (state_r == IDLE) && !reset;
  assign accept_s    = req_valid && req_ready;
  assign word_addr_s = {{(D_WIDTH-A_WIDTH){1'b0}}, req_addr[A_WIDTH+1:2]};

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (req_we) begin
      illegal_s = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
    end else begin
      illegal_s = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   misaligned_s = req_addr[0];
      2'b10:   misaligned_s = (req_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    latch_en_s        = 1'b0;
    rsp_valid_nxt_s   = 1'b0;
    rsp_rdata_nxt_s   = rsp_rdata;
    rsp_err_nxt_s     = rsp_err;
    ram_address_nxt_s = ram_address;
    ram_data_nxt_s    = ram_data;
    ram_wren_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (illegal_s || misaligned_s) begin
            // Rejected requests answer immediately and never touch the RAM.
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b1;
            rsp_rdata_nxt_s = 32'h00000000;
          end else begin
            latch_en_s        = 1'b1;
            ram_address_nxt_s = word_addr_s;
            if (req_we && (req_funct3 == F3_W)) begin
              // Full-word stores need no read of the old contents.
              ram_data_nxt_s = req_wdata;
              ram_wren_nxt_s = 1'b1;
              state_nxt_s    = WR;
            end else begin
              state_nxt_s = RD_ISSUE;
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ISSUE: begin
        // The RAM registers the address at the end of this cycle.
        state_nxt_s = RD_WAIT;
      end
      RD_WAIT: begin
        if (we_r) begin
          ram_data_nxt_s = merge_store(ram_q, wdata_r, funct3_r, lane_r);
          ram_wren_nxt_s = 1'b1;
          state_nxt_s    = WR;
        end else begin
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b0;
          rsp_rdata_nxt_s = extract_load(ram_q, funct3_r, lane_r);
          state_nxt_s     = IDLE;
        end
      end
      WR: begin
        // The write commits at the closing edge of this cycle.
        rsp_valid_nxt_s = 1'b1;
        rsp_err_nxt_s   = 1'b0;
        rsp_rdata_nxt_s = 32'h00000000;
        state_nxt_s     = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Register state, request context and all RAM/response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      lane_r      <= 2'b00;
      wdata_r     <= 32'h00000000;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h00000000;
      rsp_err     <= 1'b0;
      ram_address <= {D_WIDTH{1'b0}};
      ram_data    <= {D_WIDTH{1'b0}};
      ram_wren    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid   <= rsp_valid_nxt_s;
      rsp_rdata   <= rsp_rdata_nxt_s;
      rsp_err     <= rsp_err_nxt_s;
      ram_address <= ram_address_nxt_s;
      ram_data    <= ram_data_nxt_s;
      ram_wren    <= ram_wren_nxt_s;
      if (latch_en_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        lane_r   <= req_addr[1:0];
        wdata_r  <= req_wdata;
      end else begin
        we_r     <= we_r;
        funct3_r <= funct3_r;
        lane_r   <= lane_r;
        wdata_r  <= wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: a word RAM model with registered address and
// unregistered q, a behavioural memory/response model, directed cases with
// literal expectations, and a randomized request stream.
module tb_dmem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  always #5 clock = ~clock;

  dmem_lsu #(.D_WIDTH(32), .A_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // RAM model with a preload port used while the DUT is held in reset
  logic [31:0] ram_mem [0:255];
  logic [7:0]  ram_addr_q;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clock) begin
    if (pl_en) ram_mem[pl_idx] <= pl_val;
    else if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
    ram_addr_q <= ram_address[7:0];
  end
  assign ram_q = ram_mem[ram_addr_q];

  // Reference model state
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] model_mem [0:255];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          exp_wr_count = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected response queue
  task automatic cmp_cycle();
    exp_t e;
    if (ram_wren) begin
      wr_count++;
      last_wr_addr = ram_address;
      last_wr_data = ram_data;
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cycle", cyc, e.due);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        last_rdata = rsp_rdata;
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("rsp_missing", {31'b0, rsp_valid}, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    cmp_cycle();
  endtask

  // Behavioural effect of one accepted request, decided at cycle acc
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int acc);
    exp_t        e;
    logic        bad;
    int          sz;
    int          sh;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] mask;
    sz  = int'(f3[1:0]);
    sh  = 8 * int'(addr[1:0]);
    w   = model_mem[addr[9:2]];
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (sz == 1 && addr[0]) bad = 1'b1;
    if (sz == 2 && addr[1:0] != 2'b00) bad = 1'b1;
    e.err   = bad;
    e.rdata = 32'h0;
    if (bad) begin
      e.due = acc + 1;
    end else if (we) begin
      mask = (sz == 0) ? 32'h000000FF : (sz == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
      mask = mask << sh;
      model_mem[addr[9:2]] = (w & ~mask) | ((wdata << sh) & mask);
      exp_wr_count++;
      e.due = acc + ((sz == 2) ? 2 : 4);
    end else begin
      v = w >> sh;
      if (sz == 0) begin
        v = v & 32'h000000FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
        v = v & 32'h0000FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      e.rdata = v;
      e.due   = acc + 3;
    end
    exp_q.push_back(e);
  endtask

  // Present a request, wait (bounded) for acceptance, then drop req_valid
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int acc);
    int n;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 30) begin
      tick();
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      model_req(we, f3, addr, wdata, acc);
      tick();
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc1;
    int acc2;
    int snap;
    int bad_words;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          r;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    tick();
    tick();
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_ram_wren", {31'b0, ram_wren}, 32'd0);
    check("reset_ram_address", ram_address, 32'd0);
    check("reset_ram_data", ram_data, 32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);

    pl_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pl_idx = 8'(i);
      pl_val = $urandom;
      model_mem[i] = pl_val;
      tick();
    end
    pl_en = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store then word load
    do_req(1'b1, 3'b010, 32'h00000010, 32'h8899AABB, acc1);
    drain();
    check("sw_wr_addr", last_wr_addr, 32'd4);
    check("sw_wr_data", last_wr_data, 32'h8899AABB);
    do_req(1'b0, 3'b010, 32'h00000010, 32'h0, acc1);
    drain();
    check("lw_after_sw", last_rdata, 32'h8899AABB);

    // Byte store via read-modify-write
    do_req(1'b1, 3'b000, 32'h00000011, 32'h00000055, acc1);
    drain();
    check("sb_wr_data", last_wr_data, 32'h889955BB);
    check("sb_wr_addr", last_wr_addr, 32'd4);
    do_req(1'b0, 3'b010, 32'h00000010, 32'h0, acc1);
    drain();
    check("lw_after_sb", last_rdata, 32'h889955BB);

    // Sub-word loads and extension
    do_req(1'b0, 3'b000, 32'h00000013, 32'h0, acc1); drain();
    check("lb_0x13", last_rdata, 32'hFFFFFF88);
    do_req(1'b0, 3'b100, 32'h00000013, 32'h0, acc1); drain();
    check("lbu_0x13", last_rdata, 32'h00000088);
    do_req(1'b0, 3'b001, 32'h00000012, 32'h0, acc1); drain();
    check("lh_0x12", last_rdata, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h00000012, 32'h0, acc1); drain();
    check("lhu_0x12", last_rdata, 32'h00008899);

    // Error requests: one-cycle error response, no RAM write
    snap = wr_count;
    do_req(1'b0, 3'b001, 32'h00000013, 32'h0, acc1);
    do_req(1'b0, 3'b010, 32'h00000012, 32'h0, acc1);
    do_req(1'b1, 3'b010, 32'h00000011, 32'h12345678, acc1);
    do_req(1'b0, 3'b011, 32'h00000010, 32'h0, acc1);
    drain();
    check("err_no_write", wr_count, snap);

    // Reset during RD_WAIT of a halfword store
    snap = wr_count;
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h00000010; req_wdata = 32'h0000CAFE;
    req_valid = 1'b1;
    check("rst_test_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_wren", {31'b0, ram_wren}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
    tick();
    tick();
    check("rst_mid_no_write", wr_count, snap);
    do_req(1'b0, 3'b010, 32'h00000010, 32'h0, acc1);
    drain();
    check("rst_mid_word_kept", last_rdata, 32'h889955BB);

    // Back-to-back loads with req_valid held
    do_req(1'b0, 3'b010, 32'h00000010, 32'h0, acc1);
    do_req(1'b0, 3'b000, 32'h00000013, 32'h0, acc2);
    drain();
    check("b2b_spacing", acc2 - acc1, 32'd3);
    check("b2b_second_data", last_rdata, 32'hFFFFFF88);

    // Randomized request stream
    for (int i = 0; i < 400; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        rf3[1:0] = 2'($urandom_range(0, 2));
        rf3[2]   = rf3[2] & ~rwe & (rf3[1:0] != 2'b10);
      end
      r = $urandom_range(0, 3);
      if (r == 0) raddr[1:0] = 2'b00;
      else if (r == 1) raddr[0] = 1'b0;
      do_req(rwe, rf3, raddr, $urandom, acc1);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(1, 4);
        for (int k = 0; k < r; k++) tick();
      end
    end
    drain();

    tick();
    tick();
    check("write_count", wr_count, exp_wr_count);
    bad_words = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram_mem[i] !== model_mem[i]) bad_words++;
    end
    check("memory_words_differing", bad_words, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
